freq_measure_sequencer: RTL and testbench

Controls one frequency-measurement cycle for the two-digit counter path. It opens a programmable gate window, counts leading-edge pulses inside it, converts the count to tens/units, and hands the result to the display stage over a valid/ready handshake. It owns the runtime-programmable update period, with loads applied safely at window boundaries. It sits between the edge detector and the seven-segment driver.

---
 rtl/freq_pkg.sv | 16 +
 rtl/freq_measure_sequencer_bin2bcd_serial.sv | 45 ++++
 rtl/freq_measure_sequencer.sv | 127 ++++++++++++
 tb/tb_freq_measure_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-measurement path.
// Used by the sequencer and the serial BCD converter.
package freq_pkg;

   typedef enum logic [1:0] {
      S_GATE    = 2'd0,
      S_CONV    = 2'd1,
      S_PUBLISH = 2'd2
   } state_t;

   localparam int DIGIT_W    = 4;
   localparam int DEF_PERIOD = 1199;
   localparam int MAX_CNT    = 99;
   localparam int BCD_BASE   = 10;

endpackage

// File: rtl/freq_measure_sequencer_bin2bcd_serial.sv
// Serial binary-to-BCD converter by repeated subtraction of ten.
// done is high in the final conversion cycle (one digit step per clock).
module bin2bcd_serial
   import freq_pkg::*;
#(
   parameter int COUNT_BITS = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [COUNT_BITS-1:0] count,
   output logic [DIGIT_W-1:0]    tens,
   output logic [DIGIT_W-1:0]    units,
   output logic                  done
);

   logic [COUNT_BITS-1:0] work;
   logic                  active;

   // final step: remainder already below ten
   assign done = active && (work < COUNT_BITS'(BCD_BASE));

   // load on start, then peel off one ten per cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         work   <= '0;
         active <= 1'b0;
         tens   <= '0;
         units  <= '0;
      end else if (start) begin
         work   <= count;
         tens   <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (work >= COUNT_BITS'(BCD_BASE)) begin
            work <= work - COUNT_BITS'(BCD_BASE);
            tens <= tens + DIGIT_W'(1);
         end else begin
            units  <= work[DIGIT_W-1:0];
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/freq_measure_sequencer.sv
// Gate window / count / convert / publish sequencer for the
// two-digit frequency counter, with boundary-safe period reloads.
module freq_measure_sequencer
   import freq_pkg::*;
#(
   parameter int BITS           = 12,
   parameter int DEFAULT_PERIOD = DEF_PERIOD,
   parameter int COUNT_BITS     = 7,
   parameter int MAX_COUNT      = MAX_CNT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               edge_pulse,
   input  logic [BITS-1:0]    period,
   input  logic               period_load,
   output logic               gate_active,
   output logic               busy,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] units,
   output logic               overflow,
   output logic               result_valid,
   input  logic               result_ready
);

   state_t                state;
   state_t                state_next;
   logic [BITS-1:0]       win_cnt;
   logic [BITS-1:0]       act_period;
   logic [BITS-1:0]       pend_period;
   logic                  pend_flag;
   logic [COUNT_BITS-1:0] edge_cnt;
   logic [COUNT_BITS-1:0] cnt_next;
   logic                  ovf_q;
   logic                  at_max;
   logic                  win_end;
   logic                  handshake;
   logic                  conv_start;
   logic                  conv_done;

   assign at_max    = (edge_cnt == COUNT_BITS'(MAX_COUNT));
   assign win_end   = (win_cnt == act_period);
   assign handshake = result_valid && result_ready;
   assign cnt_next  = (edge_pulse && !at_max) ?
                      edge_cnt + COUNT_BITS'(1) : edge_cnt;
   assign overflow  = ovf_q;

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_GATE;
      else        state <= state_next;
   end

   // next-state and Moore outputs
   always_comb begin
      state_next   = state;
      gate_active  = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      conv_start   = 1'b0;
      case (state)
         S_GATE: begin
            gate_active = 1'b1;
            if (win_end) begin
               conv_start = 1'b1;
               state_next = S_CONV;
            end
         end
         S_CONV: begin
            busy = 1'b1;
            if (conv_done) state_next = S_PUBLISH;
         end
         S_PUBLISH: begin
            result_valid = 1'b1;
            if (result_ready) state_next = S_GATE;
         end
         default: state_next = S_GATE;
      endcase
   end

   // window timing, edge counting and overflow flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
         ovf_q    <= 1'b0;
      end else if (state == S_GATE) begin
         edge_cnt <= cnt_next;
         if (edge_pulse && at_max) ovf_q <= 1'b1;
         if (win_end) win_cnt <= '0;
         else         win_cnt <= win_cnt + BITS'(1);
      end else if (handshake) begin
         edge_cnt <= '0;
         ovf_q    <= 1'b0;
      end
   end

   // period staging: new value takes effect only at a window start
   always_ff @(posedge clk) begin
      if (!reset) begin
         act_period  <= BITS'(DEFAULT_PERIOD);
         pend_period <= '0;
         pend_flag   <= 1'b0;
      end else begin
         if (handshake && pend_flag) begin
            act_period <= pend_period;
            pend_flag  <= 1'b0;
         end
         if (period_load) begin
            pend_period <= period;
            pend_flag   <= 1'b1;
         end
      end
   end

   bin2bcd_serial #(
      .COUNT_BITS (COUNT_BITS)
   ) u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .count (cnt_next),
      .tens  (tens),
      .units (units),
      .done  (conv_done)
   );

endmodule

// File: tb/tb_freq_measure_sequencer.sv
// Self-checking bench for freq_measure_sequencer: phase-level model
// compared every cycle, plus directed literal checks.
module tb_freq_measure_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        edge_pulse = 1'b0;
   logic [11:0] period = '0;
   logic        period_load = 1'b0;
   logic        result_ready = 1'b1;
   logic        gate_active, busy, overflow, result_valid;
   logic [3:0]  tens, units;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   freq_measure_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .edge_pulse   (edge_pulse),
      .period       (period),
      .period_load  (period_load),
      .gate_active  (gate_active),
      .busy         (busy),
      .tens         (tens),
      .units        (units),
      .overflow     (overflow),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // phase model: 0 = window, 1 = converting, 2 = offering result
   int m_mode = 0, m_pos = 0, m_cnt = 0, m_conv = 0;
   int m_rt = 0, m_ru = 0, m_pt = 0, m_pu = 0;
   int m_act = 1199, m_pend = 0;
   bit m_ovf = 0, m_pv = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_mode = 0; m_pos = 0; m_cnt = 0; m_ovf = 0;
         m_act = 1199; m_pv = 0; m_pt = 0; m_pu = 0;
      end else begin
         case (m_mode)
            0: begin
               if (edge_pulse) begin
                  if (m_cnt < 99) m_cnt++;
                  else m_ovf = 1;
               end
               m_pos++;
               if (m_pos == m_act + 1) begin
                  m_mode = 1;
                  m_pos  = 0;
                  m_conv = m_cnt / 10 + 1;
                  m_rt   = m_cnt / 10;
                  m_ru   = m_cnt % 10;
               end
            end
            1: begin
               m_conv--;
               if (m_conv == 0) begin
                  m_mode = 2;
                  m_pt = m_rt;
                  m_pu = m_ru;
               end
            end
            default: begin
               if (result_ready) begin
                  m_mode = 0; m_cnt = 0; m_ovf = 0;
                  if (m_pv) begin
                     m_act = m_pend;
                     m_pv = 0;
                  end
               end
            end
         endcase
         if (period_load) begin
            m_pend = int'(period);
            m_pv = 1;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("gate_active", int'(gate_active), int'(m_mode == 0));
         chk("busy", int'(busy), int'(m_mode == 1));
         chk("result_valid", int'(result_valid), int'(m_mode == 2));
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("units", int'(units), m_pu);
         if (m_mode != 1) chk("tens", int'(tens), m_pt);
      end
   end

   // run-length monitor for gate and busy phases
   int gate_run = 0, busy_run = 0, last_gate = 0, last_busy = 0;
   always @(negedge clk) begin
      if (!reset) begin
         gate_run = 0; busy_run = 0;
      end else begin
         if (gate_active === 1'b1) gate_run++;
         else if (gate_run > 0) begin
            last_gate = gate_run; gate_run = 0;
         end
         if (busy === 1'b1) busy_run++;
         else if (busy_run > 0) begin
            last_busy = busy_run; busy_run = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic edges(input int n);
      edge_pulse = 1'b1;
      repeat (n) step();
      edge_pulse = 1'b0;
   endtask

   task automatic load(input int p);
      period = 12'(p);
      period_load = 1'b1;
      step();
      period_load = 1'b0;
   endtask

   task automatic wait_valid(input int lim);
      int n = 0;
      while (result_valid !== 1'b1 && n < lim) begin
         step();
         n++;
      end
      chk("wait_valid", int'(result_valid === 1'b1), 1);
   endtask

   task automatic result(input string tag, input int gl, input int bl,
                         input int t, input int u, input int o);
      @(negedge clk);
      #1;
      chk({tag, " gate_len"}, last_gate, gl);
      if (bl >= 0) chk({tag, " busy_len"}, last_busy, bl);
      chk({tag, " tens"}, int'(tens), t);
      chk({tag, " units"}, int'(units), u);
      chk({tag, " overflow"}, int'(overflow), o);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      #1;
      chk("rst gate", int'(gate_active), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst valid", int'(result_valid), 0);
      chk("rst tens", int'(tens), 0);
      chk("rst units", int'(units), 0);
      chk("rst ovf", int'(overflow), 0);
      reset = 1'b1;

      // default 1200-cycle window, 57 edges, stage period 9
      edges(57);
      load(9);
      wait_valid(2000);
      result("A", 1200, 6, 5, 7, 0);
      step();
      chk("A next gate", int'(gate_active), 1);

      // 10-cycle window, 3 edges, stage period 199
      edges(3);
      load(199);
      wait_valid(100);
      result("B", 10, 1, 0, 3, 0);
      step();
      chk("B next gate", int'(gate_active), 1);

      // 200-cycle window, 130 edges saturate
      edges(130);
      load(9);
      wait_valid(400);
      result("C", 200, 10, 9, 9, 1);
      step();
      chk("C next gate", int'(gate_active), 1);
      chk("C next ovf", int'(overflow), 0);

      // consumer stalls; reloads mid-window and mid-offer
      result_ready = 1'b0;
      edges(2);
      load(4);
      wait_valid(100);
      result("D", 10, -1, 0, 2, 0);
      period = 12'd19;
      for (int i = 0; i < 20; i++) begin
         edge_pulse = 1'b1;
         period_load = (i == 5);
         step();
         chk("D hold valid", int'(result_valid), 1);
         chk("D hold tens", int'(tens), 0);
         chk("D hold units", int'(units), 2);
      end
      edge_pulse = 1'b0;
      period_load = 1'b0;
      result_ready = 1'b1;
      step();
      chk("D gate after ready", int'(gate_active), 1);

      // 20-cycle window from the last staged value
      edges(5);
      wait_valid(100);
      result("E", 20, 1, 0, 5, 0);
      step();

      // reset in the middle of a conversion
      edges(15);
      for (int n = 0; n < 100 && busy !== 1'b1; n++) step();
      chk("F busy seen", int'(busy === 1'b1), 1);
      reset = 1'b0;
      step();
      chk("F rst gate", int'(gate_active), 1);
      chk("F rst busy", int'(busy), 0);
      chk("F rst valid", int'(result_valid), 0);
      chk("F rst tens", int'(tens), 0);
      chk("F rst units", int'(units), 0);
      chk("F rst ovf", int'(overflow), 0);
      step();
      reset = 1'b1;
      wait_valid(2000);
      result("F", 1200, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
